pipe_ctrl: RTL

Central pipeline sequencer for the 6-stage core (IF, ID, EX, MM1, MM2, WB). It generates the per-boundary write-enable/flush pairs consumed by reg_if_id, reg_id_ex, reg_ex_mm1, reg_mm1_mm2 and reg_mm2_wb, plus PC write-enable and redirect select. It resolves load-use, divider-busy, data-memory-wait, branch-redirect and WB-exception events by fixed priority. A small FSM inserts post-exception drain bubbles, and a counter tracks stall cycles.

---
 rtl/pipe_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central sequencer for the 6-stage pipeline (IF ID EX MM1 MM2 WB).
// Produces per-boundary write-enable/flush pairs, PC write-enable and redirect
// select. Hazards are resolved by fixed priority. A short DRAIN phase inserts
// bubbles after an exception redirect. A saturating counter records stall cycles.
module pipe_ctrl #(
  parameter int unsigned EXC_BUBBLES = 2,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rj,
  input  logic [4:0]       id_rk,
  input  logic             id_rj_ren,
  input  logic             id_rk_ren,
  input  logic             ex_mm_re,
  input  logic [4:0]       ex_reg_d,
  input  logic             mm1_mm_re,
  input  logic [4:0]       mm1_reg_d,
  input  logic             ex_div_busy,
  input  logic             mm2_dmem_wait,
  input  logic             ex_br_taken,
  input  logic             wb_excp,
  output logic             pc_wen,
  output logic [1:0]       redirect_sel,
  output logic             wen_if_id,
  output logic             flush_if_id,
  output logic             wen_id_ex,
  output logic             flush_id_ex,
  output logic             wen_ex_mm1,
  output logic             flush_ex_mm1,
  output logic             wen_mm1_mm2,
  output logic             flush_mm1_mm2,
  output logic             wen_mm2_wb,
  output logic             flush_mm2_wb,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       ctrl_state
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_DRAIN = 2'b01
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         drain_q, drain_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  // Boundary index: 0 IF/ID, 1 ID/EX, 2 EX/MM1, 3 MM1/MM2, 4 MM2/WB
  logic [4:0]         wen, flush;
  logic               load_use;
  logic               rj_hit, rk_hit;

  // Load-use detection: an ID source matches a load destination in EX or MM1
  always_comb begin
    rj_hit   = id_rj_ren && (id_rj != 5'd0) &&
               ((ex_mm_re && (id_rj == ex_reg_d)) || (mm1_mm_re && (id_rj == mm1_reg_d)));
    rk_hit   = id_rk_ren && (id_rk != 5'd0) &&
               ((ex_mm_re && (id_rk == ex_reg_d)) || (mm1_mm_re && (id_rk == mm1_reg_d)));
    load_use = rj_hit || rk_hit;
  end

  // Pipeline control outputs, combinational from inputs and state
  always_comb begin
    pc_wen       = 1'b0;
    redirect_sel = 2'b00;
    wen          = '0;
    flush        = '0;
    if (rst_n) begin
      if (state_q == ST_DRAIN) begin
        wen   = '1;
        flush = 5'b00001;
      end else begin
        pc_wen = 1'b1;
        wen    = '1;
        if (wb_excp) begin
          flush        = '1;
          redirect_sel = 2'b10;
        end else if (mm2_dmem_wait) begin
          pc_wen = 1'b0;
          wen    = 5'b10000;
          flush  = 5'b10000;
        end else if (ex_div_busy) begin
          pc_wen = 1'b0;
          wen    = 5'b11100;
          flush  = 5'b00100;
        end else if (ex_br_taken) begin
          redirect_sel = 2'b01;
          flush        = 5'b00011;
        end else if (load_use) begin
          pc_wen = 1'b0;
          wen    = 5'b11110;
          flush  = 5'b00010;
        end
      end
    end
  end

  // Next-state for FSM, drain counter and stall counter
  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    stall_cnt_d = stall_cnt_q;
    if (state_q == ST_DRAIN) begin
      drain_d = drain_q - 4'd1;
      if (drain_q <= 4'd1) begin
        state_d = ST_RUN;
        drain_d = 4'd0;
      end
    end else begin
      if (wb_excp) begin
        state_d = ST_DRAIN;
        drain_d = 4'(EXC_BUBBLES);
      end
      if (!pc_wen && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
    end
  end

  // State and counter registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      drain_q     <= 4'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign wen_if_id     = wen[0];
  assign flush_if_id   = flush[0];
  assign wen_id_ex     = wen[1];
  assign flush_id_ex   = flush[1];
  assign wen_ex_mm1    = wen[2];
  assign flush_ex_mm1  = flush[2];
  assign wen_mm1_mm2   = wen[3];
  assign flush_mm1_mm2 = flush[3];
  assign wen_mm2_wb    = wen[4];
  assign flush_mm2_wb  = flush[4];
  assign stall_cnt     = stall_cnt_q;
  assign ctrl_state    = state_q;

endmodule
